acc_icb_bridge: RTL and testbench

Parametrised ICB slave front-end for the convolution accelerator. It decodes one ICB window into a register file and NBANK word-addressed single-port SRAM banks. Each bank is arbitrated between ICB and the compute core, with ICB having priority. Unlike the previous top, it runs a proper one-outstanding command/response FSM, returns errors for bad addresses, has fixed read latency, honours byte masks on registers, self-clears the start bit, and raises a sticky done interrupt.

---
 rtl/acc_icb_bridge.sv | 260 ++++++++++++++++++++++++++
 tb/tb_acc_icb_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_icb_bridge.sv
// ICB slave front-end for the convolution accelerator.
//
// Decodes one 1 MiB ICB window (addr[31:20] == WIN_HI) into a byte-masked register file
// and NBANK word-addressed single-port SRAM banks. One command is outstanding at a time:
// register accesses, bank writes and decode errors respond one cycle after the handshake,
// and bank reads respond two cycles after it. Each bank is shared with the compute core.
// An ICB access takes the bank only in its handshake cycle; the core is stalled for that
// one cycle and must hold its request.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   icb_cmd_*                    ICB command channel (valid/ready, addr, read, wdata, wmask)
//   icb_rsp_*                    ICB response channel (valid/ready, err, rdata)
//   cfg_o                        flattened register file, reg i at [i*DW +: DW]
//   start_o                      one-cycle pulse after CTRL.START is written with 1
//   irq_o                        registered CTRL.IE & STATUS.DONE
//   core_busy_i, core_done_i     core status inputs
//   core_req/we/addr/wdata/wem   per-bank core memory requests
//   core_gnt, core_rvalid        per-bank grant and read-data-valid back to the core
//   ram_*                        per-bank SRAM macro interface (read data one cycle after cs)
module acc_icb_bridge #(
  parameter int unsigned DW      = 32,
  parameter logic [11:0] WIN_HI  = 12'h101,
  parameter int unsigned NBANK   = 3,
  parameter int unsigned BANK_AW = 13,
  parameter int unsigned NREG    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     icb_cmd_valid,
  output logic                     icb_cmd_ready,
  input  logic [31:0]              icb_cmd_addr,
  input  logic                     icb_cmd_read,
  input  logic [DW-1:0]            icb_cmd_wdata,
  input  logic [DW/8-1:0]          icb_cmd_wmask,
  output logic                     icb_rsp_valid,
  input  logic                     icb_rsp_ready,
  output logic                     icb_rsp_err,
  output logic [DW-1:0]            icb_rsp_rdata,
  output logic [NREG*DW-1:0]       cfg_o,
  output logic                     start_o,
  output logic                     irq_o,
  input  logic                     core_busy_i,
  input  logic                     core_done_i,
  input  logic [NBANK-1:0]         core_req,
  input  logic [NBANK-1:0]         core_we,
  input  logic [NBANK*BANK_AW-1:0] core_addr,
  input  logic [NBANK*DW-1:0]      core_wdata,
  input  logic [NBANK*DW/8-1:0]    core_wem,
  output logic [NBANK-1:0]         core_gnt,
  output logic [NBANK-1:0]         core_rvalid,
  output logic [NBANK-1:0]         ram_cs,
  output logic [NBANK-1:0]         ram_we,
  output logic [NBANK*BANK_AW-1:0] ram_addr,
  output logic [NBANK*DW-1:0]      ram_wdata,
  output logic [NBANK*DW/8-1:0]    ram_wem,
  input  logic [NBANK*DW-1:0]      ram_rdata
);

  localparam int unsigned MW = DW / 8;

  typedef enum logic [1:0] {StIdle, StRdWait, StRsp} state_e;

  state_e            state_q, state_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rd_bank_q, rd_bank_d;
  logic [DW-1:0]     regs_q [NREG];
  logic [DW-1:0]     regs_d [NREG];
  logic              done_q, done_d;
  logic              start_q, start_d;
  logic              irq_q, irq_d;
  logic [NBANK-1:0]  core_rvalid_q;

  // Address decode
  logic [1:0]         region;
  logic [5:0]         reg_idx;
  logic [BANK_AW-1:0] word_addr;
  logic [1:0]         bank_idx;
  logic               win_ok, bank_hi_nz, reg_sel, bank_sel, dec_err;
  logic               hs, wr_reg;
  logic [NBANK-1:0]   icb_own;
  logic [DW-1:0]      reg_rd;
  logic [DW-1:0]      bank_rdata;

  assign region     = icb_cmd_addr[19:18];
  assign reg_idx    = icb_cmd_addr[7:2];
  assign word_addr  = icb_cmd_addr[BANK_AW+1:2];
  assign bank_idx   = region - 2'd1;
  assign win_ok     = (icb_cmd_addr[31:20] == WIN_HI);
  // Bank regions must leave the bits between the word address and the region field clear.
  assign bank_hi_nz = ((icb_cmd_addr[17:0] >> (BANK_AW + 2)) != '0);
  assign reg_sel    = win_ok && (region == 2'd0) && (32'(reg_idx) < NREG);
  assign bank_sel   = win_ok && (region != 2'd0) && (32'(region) <= NBANK) && !bank_hi_nz;
  assign dec_err    = !reg_sel && !bank_sel;

  assign icb_cmd_ready = (state_q == StIdle);
  assign hs            = icb_cmd_valid && icb_cmd_ready;
  assign wr_reg        = hs && reg_sel && !icb_cmd_read;

  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_val,
                                               input logic [DW-1:0] new_val,
                                               input logic [MW-1:0] mask);
    logic [DW-1:0] r;
    r = old_val;
    for (int i = 0; i < MW; i++) begin
      if (mask[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return r;
  endfunction

  // Bank arbitration: ICB owns a bank only during its handshake cycle.
  always_comb begin
    icb_own   = '0;
    ram_cs    = core_req;
    ram_we    = core_we;
    ram_addr  = core_addr;
    ram_wdata = core_wdata;
    ram_wem   = core_wem;
    core_gnt  = core_req;
    for (int b = 0; b < NBANK; b++) begin
      icb_own[b] = hs && bank_sel && (bank_idx == 2'(b));
      if (icb_own[b]) begin
        ram_cs[b]                     = 1'b1;
        ram_we[b]                     = !icb_cmd_read;
        ram_addr[b*BANK_AW +: BANK_AW] = word_addr;
        ram_wdata[b*DW +: DW]         = icb_cmd_wdata;
        ram_wem[b*MW +: MW]           = icb_cmd_read ? '0 : icb_cmd_wmask;
        core_gnt[b]                   = 1'b0;
      end
    end
  end

  // Register read mux; STATUS is assembled live, CTRL[0] is never stored.
  always_comb begin
    reg_rd = '0;
    for (int i = 0; i < NREG; i++) begin
      if (reg_idx == 6'(i)) begin
        if (i == 1) begin
          reg_rd[0] = core_busy_i;
          reg_rd[1] = done_q;
        end else begin
          reg_rd = regs_q[i];
        end
      end
    end
  end

  always_comb begin
    bank_rdata = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (rd_bank_q == 2'(b)) bank_rdata = ram_rdata[b*DW +: DW];
    end
  end

  // Command/response FSM and register file next state
  always_comb begin
    state_d     = state_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    rd_bank_d   = rd_bank_q;
    regs_d      = regs_q;
    done_d      = done_q;
    start_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hs) begin
          if (dec_err) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = StRsp;
          end else if (reg_sel) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = icb_cmd_read ? reg_rd : '0;
            state_d     = StRsp;
          end else if (icb_cmd_read) begin
            rsp_err_d = 1'b0;
            rd_bank_d = bank_idx;
            state_d   = StRdWait;
          end else begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
            state_d     = StRsp;
          end
        end
      end
      StRdWait: begin
        rsp_rdata_d = bank_rdata;
        state_d     = StRsp;
      end
      StRsp: begin
        if (icb_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (wr_reg) begin
      for (int i = 0; i < NREG; i++) begin
        if (reg_idx == 6'(i)) begin
          if (i == 0) begin
            regs_d[0]    = byte_merge(regs_q[0], icb_cmd_wdata, icb_cmd_wmask);
            regs_d[0][0] = 1'b0;
            start_d      = icb_cmd_wmask[0] && icb_cmd_wdata[0];
          end else if (i == 1) begin
            if (icb_cmd_wmask[0] && icb_cmd_wdata[1]) done_d = 1'b0;
          end else begin
            regs_d[i] = byte_merge(regs_q[i], icb_cmd_wdata, icb_cmd_wmask);
          end
        end
      end
    end

    // A done pulse wins over a coincident write-1-to-clear.
    if (core_done_i) done_d = 1'b1;

    irq_d = regs_d[0][2] && done_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      rd_bank_q     <= '0;
      regs_q        <= '{default: '0};
      done_q        <= 1'b0;
      start_q       <= 1'b0;
      irq_q         <= 1'b0;
      core_rvalid_q <= '0;
    end else begin
      state_q       <= state_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rd_bank_q     <= rd_bank_d;
      regs_q        <= regs_d;
      done_q        <= done_d;
      start_q       <= start_d;
      irq_q         <= irq_d;
      core_rvalid_q <= core_gnt & ~core_we;
    end
  end

  assign icb_rsp_valid = (state_q == StRsp);
  assign icb_rsp_err   = rsp_err_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign start_o       = start_q;
  assign irq_o         = irq_q;
  assign core_rvalid   = core_rvalid_q;

  always_comb begin
    cfg_o = '0;
    for (int i = 0; i < NREG; i++) begin
      cfg_o[i*DW +: DW] = regs_q[i];
    end
    cfg_o[DW]     = core_busy_i;
    cfg_o[DW + 1] = done_q;
  end

endmodule

// File: tb/tb_acc_icb_bridge.sv
// Self-checking bench for acc_icb_bridge (NBANK=2 so region 3 decodes as an error).
module tb_acc_icb_bridge;
  localparam int unsigned DW      = 32;
  localparam int unsigned NBANK   = 2;
  localparam int unsigned BANK_AW = 13;
  localparam int unsigned NREG    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     icb_cmd_valid = 0, icb_cmd_ready, icb_cmd_read = 0;
  logic [31:0]              icb_cmd_addr = 0, icb_cmd_wdata = 0;
  logic [3:0]               icb_cmd_wmask = 0;
  logic                     icb_rsp_valid, icb_rsp_ready = 0, icb_rsp_err;
  logic [31:0]              icb_rsp_rdata;
  logic [NREG*DW-1:0]       cfg_o;
  logic                     start_o, irq_o;
  logic                     core_busy_i = 0, core_done_i = 0;
  logic [NBANK-1:0]         core_req = 0, core_we = 0, core_gnt, core_rvalid;
  logic [NBANK*BANK_AW-1:0] core_addr = 0, ram_addr;
  logic [NBANK*DW-1:0]      core_wdata = 0, ram_wdata, ram_rdata;
  logic [NBANK*DW/8-1:0]    core_wem = 0, ram_wem;
  logic [NBANK-1:0]         ram_cs, ram_we;

  acc_icb_bridge #(
    .DW(DW), .WIN_HI(12'h101), .NBANK(NBANK), .BANK_AW(BANK_AW), .NREG(NREG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_err(icb_rsp_err),
    .icb_rsp_rdata(icb_rsp_rdata), .cfg_o(cfg_o), .start_o(start_o), .irq_o(irq_o),
    .core_busy_i(core_busy_i), .core_done_i(core_done_i), .core_req(core_req),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata), .core_wem(core_wem),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wem(ram_wem), .ram_rdata(ram_rdata)
  );

  // SRAM banks seen by the DUT
  logic [31:0] mem [NBANK][1<<BANK_AW];
  always @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      if (ram_cs[b]) begin
        if (ram_we[b]) begin
          for (int k = 0; k < 4; k++)
            if (ram_wem[b*4+k])
              mem[b][ram_addr[b*BANK_AW +: BANK_AW]][k*8 +: 8] <= ram_wdata[b*32+k*8 +: 8];
        end else begin
          ram_rdata[b*32 +: 32] <= mem[b][ram_addr[b*BANK_AW +: BANK_AW]];
        end
      end
    end
  end

  // Reference model state
  logic [31:0] m_ctrl = 0;
  logic [31:0] m_reg [NREG];
  logic        m_done = 0;
  logic [31:0] m_mem [int];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = -1, start_hi = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] m);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_cfg(input int i);
    if (i == 0) return m_ctrl;
    if (i == 1) return {30'b0, m_done, core_busy_i};
    return m_reg[i];
  endfunction

  // Transaction-level model: expected response and side effects of one ICB command.
  function automatic void model_cmd(input logic [31:0] a, input bit rd, input logic [31:0] wd,
                                    input logic [3:0] wm, output logic [31:0] erd,
                                    output bit eerr, output int elat, output int ebank,
                                    output int eword, output bit estart);
    int region = int'(a[19:18]);
    int idx = int'(a[7:2]);
    int key;
    erd = 0; eerr = 0; elat = 1; ebank = -1; eword = 0; estart = 0;
    if (a[31:20] != 12'h101 || region > NBANK) eerr = 1;
    else if (region == 0 && idx >= NREG) eerr = 1;
    else if (region != 0 && a[17:BANK_AW+2] != 0) eerr = 1;
    if (eerr) return;
    if (region == 0) begin
      if (rd) erd = m_cfg(idx);
      else if (idx == 0) begin
        m_ctrl = mmerge(m_ctrl, wd, wm) & ~32'h1;
        estart = wm[0] & wd[0];
      end else if (idx == 1) begin
        if (wm[0] && wd[1]) m_done = 0;
      end else m_reg[idx] = mmerge(m_reg[idx], wd, wm);
    end else begin
      ebank = region - 1;
      eword = int'(a[BANK_AW+1:2]);
      key = ebank * (1 << BANK_AW) + eword;
      if (rd) begin
        elat = 2;
        erd = m_mem.exists(key) ? m_mem[key] : 32'h0;
      end else begin
        m_mem[key] = mmerge(m_mem.exists(key) ? m_mem[key] : 32'h0, wd, wm);
      end
    end
  endfunction

  // Per-cycle compare of the continuously meaningful outputs
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NREG; i++)
        check($sformatf("cfg_o[%0d]", i), 64'(cfg_o[i*32 +: 32]), 64'(m_cfg(i)));
      check("irq_o", 64'(irq_o), 64'(m_ctrl[2] & m_done));
      check("start_o", 64'(start_o), 64'(cyc == start_cyc));
      if (start_o) start_hi++;
    end
  end

  task automatic do_cmd(input string name, input logic [31:0] a, input bit rd,
                        input logic [31:0] wd, input logic [3:0] wm, input int hold,
                        input bit with_done, output logic [31:0] got, output logic got_err);
    logic [31:0] erd, r0;
    bit eerr, estart;
    logic e0;
    int elat, ebank, eword, lat;
    @(posedge clk); #1;
    icb_cmd_valid = 1; icb_cmd_addr = a; icb_cmd_read = rd;
    icb_cmd_wdata = wd; icb_cmd_wmask = wm; core_done_i = with_done;
    @(negedge clk); #1;
    model_cmd(a, rd, wd, wm, erd, eerr, elat, ebank, eword, estart);
    if (with_done) m_done = 1;
    if (estart) start_cyc = cyc + 1;
    check({name, " cmd_ready"}, 64'(icb_cmd_ready), 64'd1);
    if (ebank >= 0) begin
      check({name, " ram_cs"}, 64'(ram_cs[ebank]), 64'd1);
      check({name, " ram_we"}, 64'(ram_we[ebank]), 64'(!rd));
      check({name, " ram_addr"}, 64'(ram_addr[ebank*BANK_AW +: BANK_AW]), 64'(eword));
      if (!rd) begin
        check({name, " ram_wem"}, 64'(ram_wem[ebank*4 +: 4]), 64'(wm));
        check({name, " ram_wdata"}, 64'(ram_wdata[ebank*32 +: 32]), 64'(wd));
      end
    end else begin
      check({name, " ram_cs idle"}, 64'(ram_cs), 64'd0);
    end
    @(posedge clk); #1;
    icb_cmd_valid = 0; core_done_i = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!icb_rsp_valid && lat < 8);
    check({name, " latency"}, 64'(lat), 64'(elat));
    check({name, " rsp_err"}, 64'(icb_rsp_err), 64'(eerr));
    check({name, " rsp_rdata"}, 64'(icb_rsp_rdata), 64'(erd));
    r0 = icb_rsp_rdata; e0 = icb_rsp_err; got = r0; got_err = e0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, " hold valid"}, 64'(icb_rsp_valid), 64'd1);
      check({name, " hold rdata"}, 64'(icb_rsp_rdata), 64'(r0));
      check({name, " hold err"}, 64'(icb_rsp_err), 64'(e0));
      check({name, " hold cmd_ready"}, 64'(icb_cmd_ready), 64'd0);
    end
    @(posedge clk); #1 icb_rsp_ready = 1;
    @(negedge clk);
    check({name, " ready-cycle valid"}, 64'(icb_rsp_valid), 64'd1);
    check({name, " ready-cycle cmd_ready"}, 64'(icb_cmd_ready), 64'd0);
    @(posedge clk); #1 icb_rsp_ready = 0;
    @(negedge clk);
    check({name, " back idle valid"}, 64'(icb_rsp_valid), 64'd0);
    check({name, " back idle cmd_ready"}, 64'(icb_cmd_ready), 64'd1);
  endtask

  task automatic pulse_done;
    @(posedge clk); #1 core_done_i = 1;
    @(negedge clk); #1 m_done = 1;
    @(posedge clk); #1 core_done_i = 0;
  endtask

  task automatic check_reset_state(input string name);
    check({name, " rsp_valid"}, 64'(icb_rsp_valid), 64'd0);
    check({name, " rsp_err"}, 64'(icb_rsp_err), 64'd0);
    check({name, " rsp_rdata"}, 64'(icb_rsp_rdata), 64'd0);
    check({name, " cmd_ready"}, 64'(icb_cmd_ready), 64'd1);
    check({name, " start_o"}, 64'(start_o), 64'd0);
    check({name, " irq_o"}, 64'(irq_o), 64'd0);
    check({name, " core_rvalid"}, 64'(core_rvalid), 64'd0);
    check({name, " cfg_o zero"}, 64'(cfg_o != '0), 64'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic gerr;
    for (int i = 0; i < NREG; i++) m_reg[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check_reset_state("reset");
    chk_en = 1;

    // CTRL: byte-masked write, START self-clears and pulses once
    do_cmd("ctrl wr", 32'h1010_0000, 0, 32'hA5A5_0003, 4'b0011, 0, 0, got, gerr);
    do_cmd("ctrl rd", 32'h1010_0000, 1, 32'h0, 4'h0, 0, 0, got, gerr);
    check("ctrl literal", 64'(got), 64'h0000_0002);
    check("start pulse count", 64'(start_hi), 64'd1);

    // Bank 1 write and read-back, then a partial-mask overwrite
    do_cmd("bank1 wr", 32'h1018_0010, 0, 32'h1234_5678, 4'hF, 0, 0, got, gerr);
    do_cmd("bank1 rd", 32'h1018_0010, 1, 32'h0, 4'h0, 0, 0, got, gerr);
    check("bank1 literal", 64'(got), 64'h1234_5678);
    do_cmd("bank1 wr mask", 32'h1018_0010, 0, 32'hFFFF_FFFF, 4'b0100, 0, 0, got, gerr);
    do_cmd("bank1 rd mask", 32'h1018_0010, 1, 32'h0, 4'h0, 0, 0, got, gerr);
    check("bank1 mask literal", 64'(got), 64'h12FF_5678);

    // Decode errors
    do_cmd("err window", 32'h1020_0000, 1, 32'h0, 4'h0, 0, 0, got, gerr);
    check("err window literal", 64'({gerr, got}), 64'h1_0000_0000);
    do_cmd("err region", 32'h101C_0000, 1, 32'h0, 4'h0, 0, 0, got, gerr);
    check("err region literal", 64'({gerr, got}), 64'h1_0000_0000);
    do_cmd("err nreg", 32'h1010_0020, 0, 32'hFFFF_FFFF, 4'hF, 0, 0, got, gerr);
    check("err nreg literal", 64'(gerr), 64'd1);
    do_cmd("err bank hi", 32'h1014_8000, 0, 32'hFFFF_FFFF, 4'hF, 0, 0, got, gerr);
    check("err bank hi literal", 64'(gerr), 64'd1);

    // Response held off for 5 cycles
    do_cmd("reg2 wr", 32'h1010_0008, 0, 32'hDEAD_BEEF, 4'b0101, 0, 0, got, gerr);
    do_cmd("reg2 rd hold", 32'h1010_0008, 1, 32'h0, 4'h0, 5, 0, got, gerr);
    check("reg2 literal", 64'(got), 64'h00AD_00EF);

    // Core read on bank 0 held across an ICB write to bank 0
    begin
      logic [31:0] erd;
      bit eerr, estart;
      int elat, ebank, eword;
      @(posedge clk); #1;
      core_req = 2'b01; core_we = 2'b00; core_addr = '0; core_addr[BANK_AW-1:0] = 13'd7;
      icb_cmd_valid = 1; icb_cmd_addr = 32'h1014_0008; icb_cmd_read = 0;
      icb_cmd_wdata = 32'hCAFE_F00D; icb_cmd_wmask = 4'hF; icb_rsp_ready = 1;
      @(negedge clk); #1;
      model_cmd(32'h1014_0008, 0, 32'hCAFE_F00D, 4'hF, erd, eerr, elat, ebank, eword, estart);
      check("arb gnt hs", 64'(core_gnt[0]), 64'd0);
      check("arb ram_we hs", 64'(ram_we[0]), 64'd1);
      check("arb ram_addr hs", 64'(ram_addr[BANK_AW-1:0]), 64'd2);
      check("arb rvalid hs", 64'(core_rvalid[0]), 64'd0);
      @(posedge clk); #1 icb_cmd_valid = 0;
      @(negedge clk);
      check("arb gnt next", 64'(core_gnt[0]), 64'd1);
      check("arb ram core addr", 64'(ram_addr[BANK_AW-1:0]), 64'd7);
      check("arb ram core we", 64'(ram_we[0]), 64'd0);
      check("arb rvalid next", 64'(core_rvalid[0]), 64'd0);
      check("arb rsp_valid", 64'(icb_rsp_valid), 64'd1);
      @(posedge clk); #1 core_req = 2'b00; icb_rsp_ready = 0;
      @(negedge clk);
      check("arb rvalid after gnt", 64'(core_rvalid[0]), 64'd1);
      check("arb idle", 64'({icb_rsp_valid, icb_cmd_ready}), 64'b01);
      @(posedge clk);
      @(negedge clk);
      check("arb rvalid drop", 64'(core_rvalid[0]), 64'd0);
    end
    do_cmd("bank0 rd", 32'h1014_0008, 1, 32'h0, 4'h0, 0, 0, got, gerr);
    check("bank0 literal", 64'(got), 64'hCAFE_F00D);

    // Interrupt and sticky DONE
    do_cmd("ie wr", 32'h1010_0000, 0, 32'h0000_0004, 4'hF, 0, 0, got, gerr);
    pulse_done();
    @(negedge clk);
    check("irq literal", 64'(irq_o), 64'd1);
    @(posedge clk); #1 core_busy_i = 1;
    do_cmd("status rd", 32'h1010_0004, 1, 32'h0, 4'h0, 0, 0, got, gerr);
    check("status literal", 64'(got), 64'h3);
    do_cmd("status clr+done", 32'h1010_0004, 0, 32'h0000_0002, 4'hF, 0, 1, got, gerr);
    do_cmd("status rd2", 32'h1010_0004, 1, 32'h0, 4'h0, 0, 0, got, gerr);
    check("status sticky literal", 64'(got), 64'h3);
    do_cmd("status clr", 32'h1010_0004, 0, 32'h0000_0002, 4'hF, 0, 0, got, gerr);
    do_cmd("status rd3", 32'h1010_0004, 1, 32'h0, 4'h0, 0, 0, got, gerr);
    check("status cleared literal", 64'({irq_o, got}), 64'h0_0000_0001);
    pulse_done();
    @(negedge clk);
    check("irq again literal", 64'(irq_o), 64'd1);

    // One-cycle reset returns every output to zero
    @(posedge clk); #1;
    chk_en = 0; core_busy_i = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    m_ctrl = 0; m_done = 0; start_cyc = -1;
    for (int i = 0; i < NREG; i++) m_reg[i] = 0;
    @(negedge clk);
    check_reset_state("mid reset");
    chk_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
